// File: rtl/led_chaser_pkg.sv
// Shared encodings for the LED chaser: pattern modes, ping-pong direction, bar phase.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package led_chaser_pkg;

  typedef enum logic [1:0] {
    MODE_L2R  = 2'b00,
    MODE_R2L  = 2'b01,
    MODE_PING = 2'b10,
    MODE_BAR  = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

  typedef enum logic {
    PHASE_FILL  = 1'b0,
    PHASE_DRAIN = 1'b1
  } phase_e;

endpackage

// File: rtl/led_chaser_if.sv
// Control and display bundle of the LED chaser (run enable, mode, step divisor, pattern, pulses).
// Latency: none (wiring only).
// Backpressure: none; outputs are free-running status, inputs are sampled every cycle.
interface led_chaser_if #(
  parameter int N_LEDS    = 8,
  parameter int DIV_WIDTH = 24
);
  logic                 en;
  logic [1:0]           mode;
  logic [DIV_WIDTH-1:0] div;
  logic [N_LEDS-1:0]    led;
  logic                 tick;
  logic                 wrap;

  modport master (output en, mode, div, input led, tick, wrap);
  modport slave  (input en, mode, div, output led, tick, wrap);
endinterface

// File: rtl/led_tick_gen.sv
// Step prescaler: counts 0..div while enabled and flags the terminal count on tick_raw.
// Latency: tick_raw is combinational from the count register; first flag div+1 enabled cycles after clear.
// Backpressure: en low freezes the count; clr has priority and suppresses tick_raw.
module led_tick_gen #(
  parameter int DIV_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clr,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick_raw
);

  logic [DIV_WIDTH-1:0] count;

  // A count already above a freshly lowered div is at no terminal, so it never ticks.
  assign tick_raw = en && !clr && (count == div);

  // Count up to div and wrap; a count stranded above div clears silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (count >= div) count <= '0;
      else              count <= count + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/led_chaser.sv
// LED chaser: steps a one-hot / ping-pong / bar pattern once per prescaler period.
// Latency: led, tick and wrap are registered; first step div+1 enabled cycles after the 2-cycle reset-release sync.
// Backpressure: en low freezes prescaler and pattern; a mode change reloads the start pattern with no tick.
module led_chaser
  import led_chaser_pkg::*;
#(
  parameter int N_LEDS    = 8,
  parameter int DIV_WIDTH = 24
) (
  input  logic         clk,
  input  logic         reset,
  led_chaser_if.slave  bus
);

  localparam logic [N_LEDS-1:0] ONE_MSB = {1'b1, {(N_LEDS-1){1'b0}}};
  localparam logic [N_LEDS-1:0] ONE_LSB = {{(N_LEDS-1){1'b0}}, 1'b1};

  logic [1:0]        rst_sync;
  logic              active;
  logic              run;
  logic              mode_chg;
  logic              tick_raw;
  mode_e             mode_in;
  mode_e             mode_q;
  dir_e              dir_q, dir_nxt;
  phase_e            phase_q, phase_nxt;
  logic [N_LEDS-1:0] led_q, led_nxt;
  logic              wrap_nxt;
  logic              tick_q, wrap_q;

  function automatic logic [N_LEDS-1:0] start_pat(mode_e m);
    return (m == MODE_R2L) ? ONE_LSB : ONE_MSB;
  endfunction

  // Reset asserts immediately but releases two edges later, keeping the core idle meanwhile.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign active   = rst_sync[1];
  assign mode_in  = mode_e'(bus.mode);
  assign run      = active && bus.en;
  assign mode_chg = run && (mode_in != mode_q);

  led_tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .en       (run),
    .clr      (mode_chg),
    .div      (bus.div),
    .tick_raw (tick_raw)
  );

  // Next pattern for one step in the current mode, plus whether it lands on the start pattern.
  always_comb begin
    led_nxt   = led_q;
    dir_nxt   = dir_q;
    phase_nxt = phase_q;
    wrap_nxt  = 1'b0;
    case (mode_q)
      MODE_L2R: begin
        if (led_q[0]) begin
          led_nxt  = ONE_MSB;
          wrap_nxt = 1'b1;
        end else begin
          led_nxt = led_q >> 1;
        end
      end
      MODE_R2L: begin
        if (led_q[N_LEDS-1]) begin
          led_nxt  = ONE_LSB;
          wrap_nxt = 1'b1;
        end else begin
          led_nxt = led_q << 1;
        end
      end
      MODE_PING: begin
        // Turn around on arrival at an end so each endpoint shows only once per period.
        if (dir_q == DIR_RIGHT) begin
          led_nxt = led_q >> 1;
          if (led_q[1]) dir_nxt = DIR_LEFT;
        end else begin
          led_nxt = led_q << 1;
          if (led_q[N_LEDS-2]) begin
            dir_nxt  = DIR_RIGHT;
            wrap_nxt = 1'b1;
          end
        end
      end
      MODE_BAR: begin
        if (phase_q == PHASE_FILL) begin
          led_nxt = {1'b1, led_q[N_LEDS-1:1]};
          if (&led_q[N_LEDS-1:1]) phase_nxt = PHASE_DRAIN;
        end else if (led_q == '0) begin
          led_nxt   = ONE_MSB;
          phase_nxt = PHASE_FILL;
          wrap_nxt  = 1'b1;
        end else begin
          led_nxt = {1'b0, led_q[N_LEDS-1:1]};
        end
      end
      default: ;
    endcase
  end

  // Pattern state: a mode change reloads the start pattern and wins over a coincident step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q   <= ONE_MSB;
      mode_q  <= MODE_L2R;
      dir_q   <= DIR_RIGHT;
      phase_q <= PHASE_FILL;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      if (mode_chg) begin
        led_q   <= start_pat(mode_in);
        mode_q  <= mode_in;
        dir_q   <= DIR_RIGHT;
        phase_q <= PHASE_FILL;
      end else if (tick_raw) begin
        led_q   <= led_nxt;
        dir_q   <= dir_nxt;
        phase_q <= phase_nxt;
        tick_q  <= 1'b1;
        wrap_q  <= wrap_nxt;
      end
    end
  end

  assign bus.led  = led_q;
  assign bus.tick = tick_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_led_chaser.sv
// Bench for led_chaser (N_LEDS=8): scenario tasks against a sequence-index reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: en toggled to exercise freezing.
module tb_led_chaser;

  localparam int N  = 8;
  localparam int DW = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  led_chaser_if #(.N_LEDS(N), .DIV_WIDTH(DW)) bus ();

  led_chaser #(.N_LEDS(N), .DIV_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: position within the mode's periodic sequence, not the shift mechanics.
  int       m_sync;
  int       m_mq;
  int       m_idx;
  int       m_cnt;
  logic     m_tick;
  logic     m_wrap;

  function automatic int period(int mq);
    case (mq)
      0, 1:    return N;
      2:       return 2 * N - 2;
      default: return 2 * N;
    endcase
  endfunction

  function automatic logic [7:0] exp_led(int mq, int idx);
    logic [7:0] one_hi;
    logic [7:0] one_lo;
    logic [7:0] ones;
    int pos;
    one_hi = 8'h80;
    one_lo = 8'h01;
    ones   = 8'hFF;
    case (mq)
      0: return one_hi >> idx;
      1: return one_lo << idx;
      2: begin
        pos = (idx < N) ? (N - 1 - idx) : (idx - (N - 1));
        return one_lo << pos;
      end
      default: begin
        if (idx < N) return ~(ones >> (idx + 1));
        return ones >> (idx - N + 1);
      end
    endcase
  endfunction

  function automatic logic [7:0] m_led();
    return exp_led(m_mq, m_idx);
  endfunction

  task automatic model_reset();
    m_sync = 0; m_mq = 0; m_idx = 0; m_cnt = 0; m_tick = 1'b0; m_wrap = 1'b0;
  endtask

  // Advance the model with the inputs present at the coming edge, then step the DUT.
  task automatic cycle();
    int d;
    d = int'(bus.div);
    m_tick = 1'b0;
    m_wrap = 1'b0;
    if (!reset) model_reset();
    else if (m_sync < 2) m_sync++;
    else if (bus.en) begin
      if (int'(bus.mode) != m_mq) begin
        m_mq = int'(bus.mode); m_idx = 0; m_cnt = 0;
      end else if (m_cnt == d) begin
        m_cnt  = 0;
        m_idx  = (m_idx + 1) % period(m_mq);
        m_tick = 1'b1;
        m_wrap = (m_idx == 0);
      end else if (m_cnt > d) m_cnt = 0;
      else m_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic [1:0] mode, input logic [DW-1:0] div);
    reset = 1'b0;
    model_reset();
    bus.mode = mode;
    bus.div  = div;
    bus.en   = 1'b1;
    cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    bus.en = 1'b1; bus.mode = 2'b00; bus.div = 8'd2;
    reset = 1'b0;
    model_reset();
    repeat (3) cycle();
    n_tests++; if (bus.led !== 8'h80) begin n_fail++; $display("FAIL reset_led got %h want 80", bus.led); end
    n_tests++; if (bus.tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b want 0", bus.tick); end
    n_tests++; if (bus.wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got %b want 0", bus.wrap); end
    reset = 1'b1;
    // div=2: two sync edges, then three prescaler edges -> first tick on edge 5.
    for (int i = 1; i <= 6; i++) begin
      cycle();
      n_tests++;
      if (bus.tick !== (i == 5)) begin n_fail++; $display("FAIL first_tick edge %0d got %b want %b", i, bus.tick, (i == 5)); end
      n_tests++;
      if (bus.led !== ((i >= 5) ? 8'h40 : 8'h80)) begin n_fail++; $display("FAIL first_led edge %0d got %h", i, bus.led); end
    end
  endtask

  task automatic test_l2r();
    logic [7:0] lit [9] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
    int k = 1;
    restart(2'b00, 8'd0);
    for (int i = 0; i < 20; i++) begin
      cycle();
      n_tests++; if (bus.led !== m_led()) begin n_fail++; $display("FAIL l2r_led cyc %0d got %h want %h", i, bus.led, m_led()); end
      n_tests++; if (bus.tick !== m_tick) begin n_fail++; $display("FAIL l2r_tick cyc %0d got %b want %b", i, bus.tick, m_tick); end
      n_tests++; if (bus.wrap !== m_wrap) begin n_fail++; $display("FAIL l2r_wrap cyc %0d got %b want %b", i, bus.wrap, m_wrap); end
      if (bus.tick && k < 9) begin
        n_tests++; if (bus.led !== lit[k]) begin n_fail++; $display("FAIL l2r_seq step %0d got %h want %h", k, bus.led, lit[k]); end
        n_tests++; if (bus.wrap !== (k == 8)) begin n_fail++; $display("FAIL l2r_seqwrap step %0d got %b", k, bus.wrap); end
        k++;
      end
    end
  endtask

  task automatic test_ping();
    int ticks = 0, n01 = 0, n80 = 0, last = -1;
    restart(2'b10, 8'd3);
    for (int i = 0; i < 130; i++) begin
      cycle();
      n_tests++; if (bus.led !== m_led()) begin n_fail++; $display("FAIL ping_led cyc %0d got %h want %h", i, bus.led, m_led()); end
      n_tests++; if (bus.tick !== m_tick) begin n_fail++; $display("FAIL ping_tick cyc %0d got %b want %b", i, bus.tick, m_tick); end
      n_tests++; if (bus.wrap !== m_wrap) begin n_fail++; $display("FAIL ping_wrap cyc %0d got %b want %b", i, bus.wrap, m_wrap); end
      if (bus.tick) begin
        if (last >= 0) begin
          n_tests++; if (i - last != 4) begin n_fail++; $display("FAIL ping_spacing got %0d want 4", i - last); end
        end
        last = i;
        if (ticks < 14) begin
          if (bus.led == 8'h01) n01++;
          if (bus.led == 8'h80) n80++;
        end
        ticks++;
      end
    end
    n_tests++; if (n01 != 1) begin n_fail++; $display("FAIL ping_01_count got %0d want 1", n01); end
    n_tests++; if (n80 != 1) begin n_fail++; $display("FAIL ping_80_count got %0d want 1", n80); end
  endtask

  task automatic test_bar();
    logic [7:0] lit [17] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
                             8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00, 8'h80};
    int k = 1;
    restart(2'b11, 8'd0);
    for (int i = 0; i < 40; i++) begin
      cycle();
      n_tests++; if (bus.led !== m_led()) begin n_fail++; $display("FAIL bar_led cyc %0d got %h want %h", i, bus.led, m_led()); end
      n_tests++; if (bus.wrap !== m_wrap) begin n_fail++; $display("FAIL bar_wrap cyc %0d got %b want %b", i, bus.wrap, m_wrap); end
      if (bus.tick && k < 17) begin
        n_tests++; if (bus.led !== lit[k]) begin n_fail++; $display("FAIL bar_seq step %0d got %h want %h", k, bus.led, lit[k]); end
        n_tests++; if (bus.wrap !== (k == 16)) begin n_fail++; $display("FAIL bar_seqwrap step %0d got %b", k, bus.wrap); end
        k++;
      end
    end
  endtask

  task automatic test_mode_switch();
    int guard = 0;
    int k = 0;
    restart(2'b00, 8'd4);
    while (!(bus.led == 8'h10 && m_cnt == 2) && guard < 200) begin cycle(); guard++; end
    n_tests++; if (guard >= 200) begin n_fail++; $display("FAIL switch_wait timeout led %h", bus.led); end
    bus.mode = 2'b01;
    cycle();
    n_tests++; if (bus.led !== 8'h01) begin n_fail++; $display("FAIL switch_led got %h want 01", bus.led); end
    n_tests++; if (bus.tick !== 1'b0) begin n_fail++; $display("FAIL switch_tick got %b want 0", bus.tick); end
    do begin cycle(); k++; end while (!bus.tick && k < 20);
    n_tests++; if (k != 5) begin n_fail++; $display("FAIL switch_restart got %0d cycles want 5", k); end
    n_tests++; if (bus.led !== 8'h02) begin n_fail++; $display("FAIL switch_next got %h want 02", bus.led); end
  endtask

  task automatic test_freeze();
    int guard = 0;
    int k = 0;
    restart(2'b00, 8'd2);
    while (!(bus.led == 8'h20 && m_cnt == 1) && guard < 200) begin cycle(); guard++; end
    n_tests++; if (guard >= 200) begin n_fail++; $display("FAIL freeze_wait timeout led %h", bus.led); end
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_tests++; if (bus.led !== 8'h20) begin n_fail++; $display("FAIL freeze_led cyc %0d got %h want 20", i, bus.led); end
      n_tests++; if (bus.tick !== 1'b0) begin n_fail++; $display("FAIL freeze_tick cyc %0d got %b want 0", i, bus.tick); end
    end
    bus.en = 1'b1;
    do begin cycle(); k++; end while (!bus.tick && k < 20);
    n_tests++; if (k != 2) begin n_fail++; $display("FAIL freeze_resume got %0d cycles want 2", k); end
    n_tests++; if (bus.led !== 8'h10) begin n_fail++; $display("FAIL freeze_next got %h want 10", bus.led); end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    restart(2'b10, 8'd0);
    while (!(bus.led == 8'h04 && m_idx >= N) && guard < 200) begin cycle(); guard++; end
    n_tests++; if (guard >= 200) begin n_fail++; $display("FAIL rstmid_wait timeout led %h", bus.led); end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    n_tests++; if (bus.led !== 8'h80) begin n_fail++; $display("FAIL rstmid_led got %h want 80", bus.led); end
    n_tests++; if (bus.tick !== 1'b0) begin n_fail++; $display("FAIL rstmid_tick got %b want 0", bus.tick); end
    cycle();
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      n_tests++; if (bus.led !== m_led()) begin n_fail++; $display("FAIL rstmid_seq cyc %0d got %h want %h", i, bus.led, m_led()); end
      n_tests++; if (bus.tick !== m_tick) begin n_fail++; $display("FAIL rstmid_tick cyc %0d got %b want %b", i, bus.tick, m_tick); end
    end
  endtask

  task automatic test_random();
    restart(2'b00, 8'd1);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) bus.div  = 8'($urandom_range(0, 6));
      bus.en = ($urandom_range(0, 9) != 0);
      cycle();
      n_tests++; if (bus.led !== m_led()) begin n_fail++; $display("FAIL rand_led cyc %0d got %h want %h", i, bus.led, m_led()); end
      n_tests++; if (bus.tick !== m_tick) begin n_fail++; $display("FAIL rand_tick cyc %0d got %b want %b", i, bus.tick, m_tick); end
      n_tests++; if (bus.wrap !== m_wrap) begin n_fail++; $display("FAIL rand_wrap cyc %0d got %b want %b", i, bus.wrap, m_wrap); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_l2r();
    test_ping();
    test_bar();
    test_mode_switch();
    test_freeze();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_chaser.md
LED_CHASER -- requirements
Module: led_chaser

Interface
REQ-001 Parameter N_LEDS, default 8, number of LED outputs; legal range 2..32.
REQ-002 Parameter DIV_WIDTH, default 24, width of the step-period divisor.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  high = run; low = freeze prescaler and pattern.
REQ-006 mode  input  2  00 left-to-right, 01 right-to-left, 10 ping-pong, 11 bar fill/drain.
REQ-007 div  input  DIV_WIDTH  step period minus one, in clk cycles.
REQ-008 led  output  N_LEDS  LED pattern; led[N_LEDS-1] is leftmost.
REQ-009 tick  output  1  one-cycle pulse on every cycle in which led advances.
REQ-010 wrap  output  1  one-cycle pulse coincident with tick when led returns to the mode start pattern.

Function
REQ-011 Prescaler counts 0..div while en=1; at count==div it asserts tick, clears to 0; div=0 gives tick every cycle.
REQ-012 If div is lowered below the current count, the prescaler SHALL clear to 0 on the next cycle without issuing tick.
REQ-013 en=0 SHALL hold count, led, direction and mode_q unchanged; tick and wrap SHALL be 0.
REQ-014 Start patterns: mode 00 one-hot MSB; 01 one-hot LSB; 10 one-hot MSB, direction right; 11 one-hot MSB.
REQ-015 Mode 00: each tick shifts led one place right; from one-hot LSB it reloads one-hot MSB (period N_LEDS), with wrap asserted.
REQ-016 Mode 01: mirror of REQ-015 (shift left, LSB reload, period N_LEDS).
REQ-017 Mode 10: shift right until LSB, reverse, shift left until MSB, reverse; endpoints not repeated; period 2*N_LEDS-2; wrap on return to MSB.
REQ-018 Mode 11: fill phase shifts right inserting 1 at MSB until all ones; drain phase shifts right inserting 0 until all zeros; next tick loads one-hot MSB; period 2*N_LEDS.
REQ-019 Registered mode_q SHALL track mode; when mode != mode_q (and en=1) the next edge loads the new start pattern, clears prescaler, updates mode_q, asserts neither tick nor wrap.
REQ-020 A mode change coinciding with a prescaler terminal count SHALL obey REQ-019 (mode change wins).
REQ-021 tick and wrap SHALL be registered outputs, aligned with the cycle led shows the new pattern.
REQ-022 led SHALL be registered; no combinational path from inputs to any output.

Reset
REQ-023 reset low SHALL immediately force led = one-hot MSB, count = 0, mode_q = 00, direction = right, fill phase = fill, tick = 0, wrap = 0.
REQ-024 Reset release SHALL be synchronised internally (two-flop release) so first tick occurs exactly div+1 enabled cycles after release plus sync delay of 2 cycles.
REQ-025 Reset asserted mid-sequence SHALL abandon the sequence; no partial pattern persists.

Structure
REQ-026 Package led_chaser_pkg SHALL hold the mode encodings (MODE_L2R, MODE_R2L, MODE_PING, MODE_BAR) and the direction/phase constants.
REQ-027 Prescaler SHALL be a sub-module led_tick_gen (clk, reset, en, clr, div -> tick_raw), parametrised by DIV_WIDTH.
REQ-028 Pattern logic SHALL be one case over mode_q in led_chaser.

Verification
REQ-029 N=8, mode 00, div=0, en=1 after reset: led 80,40,20,10,08,04,02,01,80 on consecutive ticks; wrap with the final 80.
REQ-030 N=8, mode 10, div=3: led steps every 4 cycles 80..01..80, 14 steps per period, 01 and 80 each appear once per period.
REQ-031 N=8, mode 11, div=0: 80,C0,E0,F0,F8,FC,FE,FF,7F,3F,1F,0F,07,03,01,00,80; wrap on the last 80.
REQ-032 Mode 00 at led=10, switch to 01 mid-period: next edge led=01, tick=0, prescaler restarts, next tick after div+1 cycles gives 02.
REQ-033 en low for 10 cycles at led=20, div=2: led, count frozen, tick=0; resume completes the remaining prescaler count, then 10.
REQ-034 reset pulsed low mid-sequence (led=04, mode 10 moving left): led=80 asynchronously, tick=0; after release sequence restarts per REQ-024 in mode 00 until mode_q re-syncs to mode.
